// File: rtl/avg_pkg.sv
// avg_pkg: default configuration, widths, types and helpers shared by the window averager.
package avg_pkg;
    localparam int AVG_N       = 12;
    localparam int AVG_CH      = 4;
    localparam int AVG_MAX_POW = 8;
    localparam int AVG_FRAC_W  = 4;

    localparam int CH_W  = (AVG_CH > 1) ? $clog2(AVG_CH) : 1;
    localparam int PTR_W = AVG_MAX_POW;
    localparam int SUM_W = AVG_N + AVG_MAX_POW;
    localparam int OUT_W = AVG_N + AVG_FRAC_W;
    localparam int WP_W  = $clog2(AVG_MAX_POW + 1);

    typedef logic [SUM_W-1:0]     sum_t;
    typedef logic [PTR_W-1:0]     ptr_t;
    typedef logic [AVG_MAX_POW:0] cnt_t;

    typedef enum logic [1:0] {S_RESET, S_RUN, S_FLUSH} state_t;

    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] ch;
        logic [AVG_N-1:0] data;
        logic            old_ok;
        cnt_t            cnt_after;
    } stage_t;

    function automatic logic [WP_W-1:0] clamp_pow(input logic [WP_W-1:0] p);
        return (p > WP_W'(AVG_MAX_POW)) ? WP_W'(AVG_MAX_POW) : p;
    endfunction
endpackage

// File: rtl/avg_sample_ram.sv
// avg_sample_ram: one-write one-read synchronous RAM, read-first, no reset.
module avg_sample_ram #(
    parameter int W  = 12,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/mc_window_averager.sv
// mc_window_averager: multi-channel boxcar filter, per-channel circular buffers in one shared RAM.
// Define AVG_ROUND_EN for round-half-up, saturating output instead of truncation.
module mc_window_averager
    import avg_pkg::*;
#(
    parameter int N       = AVG_N,
    parameter int CH      = AVG_CH,
    parameter int MAX_POW = AVG_MAX_POW,
    parameter int FRAC_W  = AVG_FRAC_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [$clog2(MAX_POW+1)-1:0] win_pow,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CH_W-1:0]              in_ch,
    input  logic [N-1:0]                 in_data,
    output logic                         out_valid,
    output logic [CH_W-1:0]              out_ch,
    output logic [N+FRAC_W-1:0]          out_data,
    output logic                         out_primed
);
    localparam int OW    = N + FRAC_W;
    localparam int NUM_W = SUM_W + FRAC_W + 1;

    state_t           state, state_nx;
    logic [WP_W-1:0]  win_q, win_act, pow_eff;
    cnt_t             w_len;
    sum_t             sum [CH];
    ptr_t             ptr [CH];
    cnt_t             cnt [CH];
    stage_t           sb;
    logic             accept, a_old_ok;
    ptr_t             a_ptr;
    cnt_t             a_cnt, a_cnt_nx;
    logic [N-1:0]     rdata;
    sum_t             b_sum;
    logic [NUM_W-1:0] num;
    logic [OW-1:0]    avg;

    assign pow_eff  = clamp_pow(win_act);
    assign w_len    = cnt_t'(1) << pow_eff;
    assign accept   = in_valid && in_ready;
    assign a_ptr    = ptr[in_ch];
    assign a_cnt    = cnt[in_ch];
    assign a_old_ok = a_cnt == w_len;
    assign a_cnt_nx = a_old_ok ? a_cnt : a_cnt + cnt_t'(1);
    assign b_sum    = sum[sb.ch] + sum_t'(sb.data) - (sb.old_ok ? sum_t'(rdata) : sum_t'(0));

    // The read address trails the write pointer by W; at full depth it reads the slot being overwritten.
    avg_sample_ram #(.W(N), .AW(CH_W + PTR_W)) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr ({in_ch, a_ptr}),
        .wdata (in_data),
        .re    (accept),
        .raddr ({in_ch, a_ptr - ptr_t'(w_len)}),
        .rdata (rdata)
    );

`ifdef AVG_ROUND_EN
    assign num = {1'b0, b_sum, {FRAC_W{1'b0}}} + ((NUM_W'(1) << pow_eff) >> 1);
    assign avg = ((num >> pow_eff) > NUM_W'({OW{1'b1}})) ? '1 : OW'(num >> pow_eff);
`else
    assign num = {1'b0, b_sum, {FRAC_W{1'b0}}};
    assign avg = OW'(num >> pow_eff);
`endif

    always_comb begin
        state_nx = (state == S_RUN && win_q != win_act) ? S_FLUSH : S_RUN;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_RESET;
            in_ready   <= 1'b0;
            win_q      <= '0;
            win_act    <= '0;
            sb         <= '0;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_data   <= '0;
            out_primed <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                sum[i] <= '0;
                ptr[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            state    <= state_nx;
            in_ready <= state_nx == S_RUN;
            win_q    <= win_pow;
            // The active window only moves at reset exit or in a flush, so in-flight samples keep theirs.
            win_act  <= (state == S_RESET) ? win_pow : (state == S_FLUSH) ? win_q : win_act;
            sb       <= '{accept, in_ch, in_data, a_old_ok, a_cnt_nx};
            out_valid <= sb.valid;
            if (sb.valid) begin
                out_ch     <= sb.ch;
                out_data   <= avg;
                out_primed <= sb.cnt_after == w_len;
            end
            if (state == S_FLUSH) begin
                for (int i = 0; i < CH; i++) begin
                    sum[i] <= '0;
                    ptr[i] <= '0;
                    cnt[i] <= '0;
                end
            end else begin
                if (sb.valid) sum[sb.ch] <= b_sum;
                if (accept) begin
                    ptr[in_ch] <= a_ptr + ptr_t'(1);
                    cnt[in_ch] <= a_cnt_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_mc_window_averager.sv
// tb_mc_window_averager: directed vectors with hand-computed means, latency and flush checks.
module tb_mc_window_averager;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  win_pow = 4'd2;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_ch = 2'd0;
    logic [11:0] in_data = 12'd0;
    logic        out_valid, out_primed;
    logic [1:0]  out_ch;
    logic [15:0] out_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {int due; int ch; int data; int pr;} exp_t;
    exp_t q[$];

    int e0[8] = '{880, 1160, 1400, 1600, 1600, 1600, 1600, 1600};
    int e1[8] = '{800, 1600, 2400, 3200, 3200, 3200, 3200, 3200};

    mc_window_averager dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .win_pow    (win_pow),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ch      (in_ch),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .out_data   (out_data),
        .out_primed (out_primed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (q.size() != 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            check("latency", cyc, e.due);
            check("out_valid", int'(out_valid), 1);
            if (out_valid) begin
                check("out_ch", int'(out_ch), e.ch);
                check("out_data", int'(out_data), e.data);
                check("out_primed", int'(out_primed), e.pr);
            end
        end else if (out_valid) begin
            check("spurious_out", int'(out_valid), 0);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input int d, input int exp, input int pr);
        check("in_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        in_ch    = 2'(ch);
        in_data  = 12'(d);
        q.push_back('{cyc + 2, ch, exp, pr});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic set_win(input int w);
        win_pow = 4'(w);
        tick();
        check("rdy_pre_flush", int'(in_ready), 1);
        tick();
        check("rdy_flush", int'(in_ready), 0);
        tick();
        check("rdy_post_flush", int'(in_ready), 1);
    endtask

    initial begin
        tick(2);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        reset_n = 1'b1;
        tick();
        check("ready_rise", int'(in_ready), 1);

        send(0, 10, 40, 0);
        send(0, 20, 120, 0);
        send(0, 30, 240, 0);
        send(0, 40, 400, 1);
        send(0, 50, 560, 1);

        for (int i = 0; i < 8; i++) begin
            send(0, 100, e0[i], 1);
            send(1, 200, e1[i], int'(i >= 3));
        end

        set_win(0);
        send(2, 7, 112, 1);
        send(2, 9, 144, 1);
        send(2, 11, 176, 1);

        set_win(2);
        send(0, 10, 40, 0);
        send(0, 10, 80, 0);
        send(0, 10, 120, 0);
        send(0, 10, 160, 1);
        set_win(3);
        send(0, 80, 160, 0);

        set_win(8);
`ifdef AVG_ROUND_EN
        send(3, 8, 1, 0);
`else
        send(3, 8, 0, 0);
`endif
        set_win(12);
        send(3, 32, 2, 0);

        set_win(2);
        in_valid = 1'b1;
        in_ch    = 2'd1;
        in_data  = 12'd5;
        tick();
        in_data  = 12'd6;
        tick();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_data", int'(out_data), 0);
        check("midrst_out_primed", int'(out_primed), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        tick(3);
        check("midrst_quiet", int'(out_valid), 0);
        reset_n = 1'b1;
        tick();
        check("ready_rise2", int'(in_ready), 1);
        send(0, 16, 64, 0);
        tick(4);
        check("drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
